fmul_pipe: RTL and testbench
============================

# fmul_pipe

Fully pipelined IEEE-754 single-precision multiplier with a streaming valid/ready handshake and a compile-time pipeline depth. It is the next-generation FPU multiply unit: it accepts one operation per cycle, rounds to nearest-even, and carries a user tag alongside each operation so the issue logic can match results to destinations. It sits between the FPU operand-read stage and the FPU writeback arbiter.

## Interface
- `STAGES`, default 3: register stages from input to output. Legal range 2..5.
- `TAG_W`, default 5: width of the opaque tag passed through unchanged.
- `clk` input, 1 bit: sole clock.
- `rstn` input, 1 bit: reset, synchronous, active-low.
- `x1`, `x2` input, 32 bits each: operands.
- `in_tag` input, `TAG_W` bits: tag for the operation.
- `in_valid` input, 1 bit: an operation is presented.
- `in_ready` output, 1 bit: the block accepts the operation this cycle.
- `y` output, 32 bits: result.
- `out_tag` output, `TAG_W` bits: tag of the result.
- `out_valid` output, 1 bit: `y` and `out_tag` are valid.
- `out_ready` input, 1 bit: the consumer takes the result.

## Operation
- Sign of `y` is `x1[31]` XOR `x2[31]` in every case, including zero and overflow; qNaN is the only exception.
- Zero and subnormal inputs: if either exponent is 0, the result is ±0. Subnormals are flushed to zero.
- Mantissa: P = {1,m1} × {1,m2} gives 48 bits.
  - If P[47] = 1: mantissa is P[46:24], guard bit is P[23], sticky bit is OR of P[22:0], and a normalisation carry of 1 is added to the exponent.
  - Otherwise: mantissa is P[45:23], guard bit is P[22], sticky bit is OR of P[21:0].
- Rounding is round-to-nearest-even: round up when guard AND (sticky OR mantissa LSB). If rounding overflows the mantissa, the mantissa becomes 0 and the exponent gains 1.
- Exponent: E = e1 + e2 + carries − 127, computed 10-bit signed, after rounding.
  - E ≤ 0: result is ±0.
  - E ≥ 255: result is ±inf (exponent 0xFF, mantissa 0).
- Tag and result travel in lockstep. Results leave in issue order.

## Timing
- Latency is exactly `STAGES` cycles from an accepted input (`in_valid` AND `in_ready`) to `out_valid`, when there is no backpressure.
- Throughput is 1 operation per cycle.
- Stall condition: stall = `out_valid` AND NOT `out_ready`.
  - During a stall, every stage holds its contents, including valid bits.
  - `in_ready` = NOT stall. This is combinational from `out_ready` and `out_valid`.
- `y` and `out_tag` stay stable while `out_valid` is high and `out_ready` is low.
- A bubble (`in_valid` low) propagates as a cleared valid bit. The datapath is don't-care while valid is low.
- `in_valid` high while `in_ready` is low is ignored. The source must hold the operation.
- Reset: all stage valid bits, `out_valid`, `y` and `out_tag` go to 0 on the first `clk` edge with `rstn` low.
  - Operations in flight are discarded without being emitted.
  - `in_ready` is 1 during and after reset, because `out_valid` is 0.
- Stage mapping:
  - Stage 1: registers operands and partial products.
  - Final stage: registers the rounded result.
  - Intermediate stages: hold the partial-product sum and the rounding decision.
  - `STAGES` = 2 merges the middle logic into stage 2.

## Configuration
- `FMUL_IEEE_SPECIAL_EN` defined:
  - Exponent 0xFF inputs are honoured.
  - A NaN operand gives qNaN 0x7FC00000.
  - inf × 0 gives 0x7FC00000.
  - inf × finite nonzero gives ±inf.
  - A zero or subnormal operand with a finite other operand gives ±0.
- `FMUL_IEEE_SPECIAL_EN` undefined:
  - Exponent 0xFF inputs are treated as ordinary finite values.
  - The zero rule has priority.
  - Overflow still saturates to ±inf.
  - No NaN is ever produced. This saves the special-case compare and mux logic.

## Structure
- Shared package `fpu_pkg`:
  - `fp32_t` packed struct (sign, exp[7:0], man[22:0]).
  - Constants `FP_BIAS` = 127, `FP_EXP_MAX` = 8'hFF, `FP_QNAN` = 32'h7FC00000.
  - Field widths, reused by the other FPU blocks.
- One sub-module, `fmul_mant24`: a registered 24×24 unsigned multiplier built as 6/18-bit split partial products (hh, hl, lh, ll).
  - It provides one register level and has a stall-enable input.
  - The top level owns the handshake, exponent path, rounding and special cases.

## Test plan
- Basic multiply: 0x3FC00000 × 0x40000000 (1.5 × 2.0) → y = 0x40400000 exactly `STAGES` cycles later, with `in_tag` = 7 giving `out_tag` = 7.
- Rounding tie goes to even: 0x3F800001 × 0x3FC00000 → 0x3FC00002. Sign: 0xBF800000 × 0x40000000 → 0xC0000000.
- Overflow and underflow:
  - 0x7F000000 × 0x40000000 → 0x7F800000.
  - 0x00800000 × 0x3F000000 → 0x00000000.
  - 0x00000001 (subnormal) × 0x3F800000 → 0x00000000.
- Backpressure: issue 6 back-to-back operations with tags 0..5 and drop `out_ready` for 3 cycles mid-stream.
  - All 6 results emerge in order with correct tags.
  - `in_ready` is low exactly while stalled.
  - `y` is stable during the stall.
- Reset mid-operation: issue 3 operations, then assert `rstn` = 0 for 1 cycle. `out_valid` stays 0 with no stale result; the next operation completes normally.
- Special values: 0x7F800000 × 0x00000000 → 0x7FC00000 when `FMUL_IEEE_SPECIAL_EN` is defined, and → 0x00000000 when it is not.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision field layout, format
// constants and the operand classification used by the FPU arithmetic blocks.
// No ports (package).
package fpu_pkg;

  localparam int FP_W     = 32;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;
  localparam logic [FP_W-1:0]     FP_QNAN    = 32'h7FC00000;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  // Result class decided up front from the operand exponents; CLS_NORM means
  // the exponent/mantissa datapath produces the answer.
  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fmul_cls_e;

endpackage

// File: rtl/fmul_pipe_if.sv
// Streaming handshake bundle for the FPU multiplier.
//   x1, x2, in_tag, in_valid / in_ready : operation issue side
//   y, out_tag, out_valid / out_ready   : result side
// master: the issue/consume logic around the unit; slave: the multiplier.
interface fmul_pipe_if #(
  parameter int TAG_W = 5
);
  import fpu_pkg::*;

  logic [FP_W-1:0]  x1;
  logic [FP_W-1:0]  x2;
  logic [TAG_W-1:0] in_tag;
  logic             in_valid;
  logic             in_ready;
  logic [FP_W-1:0]  y;
  logic [TAG_W-1:0] out_tag;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output x1, x2, in_tag, in_valid, out_ready,
    input  in_ready, y, out_tag, out_valid
  );

  modport slave (
    input  x1, x2, in_tag, in_valid, out_ready,
    output in_ready, y, out_tag, out_valid
  );

endinterface

// File: rtl/fmul_mant24.sv
// Registered 24x24 unsigned multiplier front end. Each operand is split into
// a 6-bit high part and an 18-bit low part; the four partial products are
// registered here and summed by the consumer.
// Ports:
//   clk               clock
//   en                load enable (low holds the registered partial products)
//   a, b              24-bit unsigned operands
//   hh_q,hl_q,lh_q,ll_q registered partial products (a_hi*b_hi, a_hi*b_lo,
//                     a_lo*b_hi, a_lo*b_lo)
module fmul_mant24 (
  input  logic        clk,
  input  logic        en,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [11:0] hh_q,
  output logic [23:0] hl_q,
  output logic [23:0] lh_q,
  output logic [35:0] ll_q
);

  logic [11:0] hh_d;
  logic [23:0] hl_d;
  logic [23:0] lh_d;
  logic [35:0] ll_d;

  always_comb begin
    hh_d = {6'd0, a[23:18]} * {6'd0, b[23:18]};
    hl_d = {18'd0, a[23:18]} * {6'd0, b[17:0]};
    lh_d = {6'd0, a[17:0]} * {18'd0, b[23:18]};
    ll_d = {18'd0, a[17:0]} * {18'd0, b[17:0]};
  end

  always_ff @(posedge clk) begin
    if (en) begin
      hh_q <= hh_d;
      hl_q <= hl_d;
      lh_q <= lh_d;
      ll_q <= ll_d;
    end
  end

endmodule

// File: rtl/fmul_pipe.sv
// Fully pipelined IEEE-754 single-precision multiplier, round-to-nearest-even,
// with an opaque tag carried in lockstep with each operation.
// Parameters:
//   STAGES  register stages from input to output, 2..5
//   TAG_W   tag width
// Ports:
//   clk     clock
//   rstn    synchronous active-low reset
//   io      fmul_pipe_if.slave (operands, tag, valid/ready both sides)
// Build option: define FMUL_IEEE_SPECIAL_EN to honour inf/NaN operands
// (exponent 0xFF); otherwise 0xFF exponents are ordinary finite values and
// no NaN is ever produced.
// Stage layout:
//   stage 1          operands class/exponents + partial products
//   stage 2 (>=3)    partial-product sum + exponent sum
//   stage 3 (>=4)    normalised mantissa + rounding decision
//   last stage(s)    rounded, packed result (STAGES=5 adds one output stage)
// The whole pipe holds while the output is stalled.
module fmul_pipe
  import fpu_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input logic       clk,
  input logic       rstn,
  fmul_pipe_if.slave io
);

  localparam bit MID_REG = (STAGES >= 3);
  localparam bit RND_REG = (STAGES >= 4);
  localparam int OUT_N   = STAGES - 1 - int'(MID_REG) - int'(RND_REG);
  localparam logic signed [9:0] BIAS10 = 10'(FP_BIAS);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             sign;
    logic [7:0]       e1;
    logic [7:0]       e2;
    fmul_cls_e        cls;
  } s1_t;

  typedef struct packed {
    logic               vld;
    logic [TAG_W-1:0]   tag;
    logic               sign;
    fmul_cls_e          cls;
    logic signed [9:0]  exp;
    logic [47:0]        prod;
  } mid_t;

  typedef struct packed {
    logic               vld;
    logic [TAG_W-1:0]   tag;
    logic               sign;
    fmul_cls_e          cls;
    logic signed [9:0]  exp;
    logic [FP_MAN_W-1:0] man;
    logic               rup;
  } rnd_t;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    fp32_t            y;
  } out_t;

  // Round-to-nearest-even increment decision.
  function automatic logic rne_up(input logic guard, input logic sticky,
                                  input logic lsb);
    return guard & (sticky | lsb);
  endfunction

  // Saturating pack: underflow flushes to signed zero, overflow to signed inf.
  function automatic fp32_t pack_result(input logic sign, input fmul_cls_e cls,
                                        input logic signed [9:0] exp,
                                        input logic [FP_MAN_W-1:0] man);
    fp32_t r;
    r.sign = sign;
    r.exp  = '0;
    r.man  = '0;
    case (cls)
      CLS_NAN:  r = FP_QNAN;
      CLS_INF:  r.exp = FP_EXP_MAX;
      CLS_ZERO: r.exp = '0;
      default: begin
        if (exp >= 10'sd255) begin
          r.exp = FP_EXP_MAX;
        end else if (exp > 10'sd0) begin
          r.exp = exp[FP_EXP_W-1:0];
          r.man = man;
        end
      end
    endcase
    return r;
  endfunction

`ifdef FMUL_IEEE_SPECIAL_EN
  function automatic fmul_cls_e classify(input fp32_t a, input fp32_t b);
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero = (a.exp == '0);
    b_zero = (b.exp == '0);
    a_inf  = (a.exp == FP_EXP_MAX) && (a.man == '0);
    b_inf  = (b.exp == FP_EXP_MAX) && (b.man == '0);
    a_nan  = (a.exp == FP_EXP_MAX) && (a.man != '0);
    b_nan  = (b.exp == FP_EXP_MAX) && (b.man != '0);
    if (a_nan || b_nan)                       return CLS_NAN;
    if ((a_inf && b_zero) || (b_inf && a_zero)) return CLS_NAN;
    if (a_inf || b_inf)                       return CLS_INF;
    if (a_zero || b_zero)                     return CLS_ZERO;
    return CLS_NORM;
  endfunction
`endif

  logic  stall;
  logic  adv;
  fp32_t op1;
  fp32_t op2;

  assign stall       = io.out_valid & ~io.out_ready;
  assign adv         = ~stall;
  assign io.in_ready = adv;
  assign op1         = io.x1;
  assign op2         = io.x2;

  // ---- stage 1: operand class, exponents, partial products ----
  s1_t         s1_d;
  s1_t         s1_q;
  logic [11:0] pp_hh;
  logic [23:0] pp_hl;
  logic [23:0] pp_lh;
  logic [35:0] pp_ll;

  always_comb begin
    s1_d.vld  = io.in_valid;
    s1_d.tag  = io.in_tag;
    s1_d.sign = op1.sign ^ op2.sign;
    s1_d.e1   = op1.exp;
    s1_d.e2   = op2.exp;
`ifdef FMUL_IEEE_SPECIAL_EN
    s1_d.cls  = classify(op1, op2);
`else
    s1_d.cls  = (op1.exp == '0 || op2.exp == '0) ? CLS_ZERO : CLS_NORM;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn)     s1_q.vld <= 1'b0;
    else if (adv)  s1_q     <= s1_d;
  end

  fmul_mant24 u_mant (
    .clk  (clk),
    .en   (adv),
    .a    ({1'b1, op1.man}),
    .b    ({1'b1, op2.man}),
    .hh_q (pp_hh),
    .hl_q (pp_hl),
    .lh_q (pp_lh),
    .ll_q (pp_ll)
  );

  // ---- stage 2: partial-product sum, biased exponent sum ----
  mid_t mid_d;
  mid_t mid_s;

  always_comb begin
    mid_d.vld  = s1_q.vld;
    mid_d.tag  = s1_q.tag;
    mid_d.sign = s1_q.sign;
    mid_d.cls  = s1_q.cls;
    mid_d.exp  = $signed({2'b00, s1_q.e1}) + $signed({2'b00, s1_q.e2}) - BIAS10;
    mid_d.prod = {pp_hh, 36'd0}
               + {5'd0, ({1'b0, pp_hl} + {1'b0, pp_lh}), 18'd0}
               + {12'd0, pp_ll};
  end

  generate
    if (MID_REG) begin : g_mid_reg
      mid_t mid_q;
      always_ff @(posedge clk) begin
        if (!rstn)    mid_q.vld <= 1'b0;
        else if (adv) mid_q     <= mid_d;
      end
      assign mid_s = mid_q;
    end else begin : g_mid_pass
      assign mid_s = mid_d;
    end
  endgenerate

  // ---- stage 3: normalise, guard/sticky, rounding decision ----
  rnd_t rnd_d;
  rnd_t rnd_s;
  logic norm;
  logic guard;
  logic sticky;

  always_comb begin
    norm      = mid_s.prod[47];
    rnd_d.vld = mid_s.vld;
    rnd_d.tag = mid_s.tag;
    rnd_d.sign = mid_s.sign;
    rnd_d.cls = mid_s.cls;
    rnd_d.exp = mid_s.exp + $signed({9'd0, norm});
    if (norm) begin
      rnd_d.man = mid_s.prod[46:24];
      guard     = mid_s.prod[23];
      sticky    = |mid_s.prod[22:0];
    end else begin
      rnd_d.man = mid_s.prod[45:23];
      guard     = mid_s.prod[22];
      sticky    = |mid_s.prod[21:0];
    end
    rnd_d.rup = rne_up(guard, sticky, rnd_d.man[0]);
  end

  generate
    if (RND_REG) begin : g_rnd_reg
      rnd_t rnd_q;
      always_ff @(posedge clk) begin
        if (!rstn)    rnd_q.vld <= 1'b0;
        else if (adv) rnd_q     <= rnd_d;
      end
      assign rnd_s = rnd_q;
    end else begin : g_rnd_pass
      assign rnd_s = rnd_d;
    end
  endgenerate

  // ---- final stage(s): apply rounding, saturate, pack ----
  out_t              out_d;
  out_t              out_q [OUT_N];
  logic [23:0]       man_r;
  logic signed [9:0] exp_f;

  always_comb begin
    // A carry into bit 23 means the mantissa rolled over to 1.0 of the next binade.
    man_r     = {1'b0, rnd_s.man} + {23'd0, rnd_s.rup};
    exp_f     = rnd_s.exp + $signed({9'd0, man_r[23]});
    out_d.vld = rnd_s.vld;
    out_d.tag = rnd_s.tag;
    out_d.y   = pack_result(rnd_s.sign, rnd_s.cls, exp_f, man_r[22:0]);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < OUT_N; i++) out_q[i] <= '0;
    end else if (adv) begin
      out_q[0] <= out_d;
      for (int i = 1; i < OUT_N; i++) out_q[i] <= out_q[i-1];
    end
  end

  assign io.out_valid = out_q[OUT_N-1].vld;
  assign io.out_tag   = out_q[OUT_N-1].tag;
  assign io.y         = out_q[OUT_N-1].y;

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe: stimulus pushes expected {tag, y} into a
// queue on acceptance; a negedge monitor pops and compares on every transfer
// and also watches in_ready and output stability during stalls.
module tb_fmul_pipe;
  import fpu_pkg::*;

  localparam int ST = 3;
  localparam int TW = 5;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   y;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fmul_pipe_if #(.TAG_W(TW)) bus ();

  fmul_pipe #(.STAGES(ST), .TAG_W(TW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  logic          mon_st;
  logic          prev_stall = 1'b0;
  logic [31:0]   prev_y;
  logic [TW-1:0] prev_tag;
  exp_t          mon_e;
  int            stall_cyc = 0;
  int            lat;

  logic [31:0] va [13];
  logic [31:0] vb [13];
  logic [31:0] ve [13];
  logic [31:0] ba [6];
  logic [31:0] bb [6];
  logic [31:0] be [6];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: all outputs sampled mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        mon_st = bus.out_valid && !bus.out_ready;
        check("in_ready", 64'(bus.in_ready), 64'(!mon_st));
        if (mon_st) stall_cyc++;
        if (prev_stall) begin
          check("hold_y", 64'(bus.y), 64'(prev_y));
          check("hold_tag", 64'(bus.out_tag), 64'(prev_tag));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got y=%h tag=%0d want no output",
                     bus.y, bus.out_tag);
          end else begin
            mon_e = sb.pop_front();
            check($sformatf("y[tag%0d]", mon_e.tag), 64'(bus.y), 64'(mon_e.y));
            check("out_tag", 64'(bus.out_tag), 64'(mon_e.tag));
          end
        end
        prev_stall = mon_st;
        prev_y     = bus.y;
        prev_tag   = bus.out_tag;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Called and returns at posedge+1; holds the operation until accepted.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [TW-1:0] t, input logic [31:0] e,
                      input bit track);
    int   waitc = 0;
    bit   acc   = 0;
    exp_t item;
    bus.x1       = a;
    bus.x2       = b;
    bus.in_tag   = t;
    bus.in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        waitc++;
        if (waitc > 50) begin
          total++;
          bad++;
          $display("FAIL send_timeout: tag=%0d in_ready stuck at 0 want 1", t);
          track = 0;
          acc   = 1;
        end
      end
    end
    if (track) begin
      item.tag = t;
      item.y   = e;
      sb.push_back(item);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d want 0", sb.size());
      sb.delete();
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    va[0]  = 32'h3F800001; vb[0]  = 32'h3FC00000; ve[0]  = 32'h3FC00002;
    va[1]  = 32'hBF800000; vb[1]  = 32'h40000000; ve[1]  = 32'hC0000000;
    va[2]  = 32'h7F000000; vb[2]  = 32'h40000000; ve[2]  = 32'h7F800000;
    va[3]  = 32'h00800000; vb[3]  = 32'h3F000000; ve[3]  = 32'h00000000;
    va[4]  = 32'h00000001; vb[4]  = 32'h3F800000; ve[4]  = 32'h00000000;
    va[5]  = 32'h3FFFFFFF; vb[5]  = 32'h3F800001; ve[5]  = 32'h40000000;
    va[6]  = 32'h80000000; vb[6]  = 32'h3F800000; ve[6]  = 32'h80000000;
    va[7]  = 32'h7F7FFFFF; vb[7]  = 32'h7F7FFFFF; ve[7]  = 32'h7F800000;
    va[8]  = 32'h7F800000; vb[8]  = 32'h00000000;
    va[9]  = 32'h7FC00000; vb[9]  = 32'h3F800000;
`ifdef FMUL_IEEE_SPECIAL_EN
    ve[8]  = 32'h7FC00000;
    ve[9]  = 32'h7FC00000;
`else
    ve[8]  = 32'h00000000;
    ve[9]  = 32'h7F800000;
`endif
    va[10] = 32'hFF800000; vb[10] = 32'h40000000; ve[10] = 32'hFF800000;
    va[11] = 32'hC0400000; vb[11] = 32'hC0400000; ve[11] = 32'h41100000;
    va[12] = 32'h80800000; vb[12] = 32'h3F000000; ve[12] = 32'h80000000;

    ba[0] = 32'h3F800000; bb[0] = 32'h3F800000; be[0] = 32'h3F800000;
    ba[1] = 32'h40000000; bb[1] = 32'h40000000; be[1] = 32'h40800000;
    ba[2] = 32'h40400000; bb[2] = 32'h40400000; be[2] = 32'h41100000;
    ba[3] = 32'h3F800000; bb[3] = 32'hC0000000; be[3] = 32'hC0000000;
    ba[4] = 32'h3FC00000; bb[4] = 32'h3FC00000; be[4] = 32'h40100000;
    ba[5] = 32'h3F800000; bb[5] = 32'h3F800001; be[5] = 32'h3F800001;

    rstn          = 1'b0;
    bus.x1        = '0;
    bus.x2        = '0;
    bus.in_tag    = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_y", 64'(bus.y), 64'(0));
    check("rst_out_tag", 64'(bus.out_tag), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end

    // Basic multiply and latency
    send(32'h3FC00000, 32'h40000000, 5'd7, 32'h40400000, 1);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(ST));
    drain();

    // Directed vectors, back to back
    for (int i = 0; i < 13; i++) send(va[i], vb[i], TW'(i), ve[i], 1);
    drain();

    // Backpressure: out_ready low for 3 cycles mid-stream
    stall_cyc = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(ba[i], bb[i], TW'(i), be[i], 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("stall_cycles", 64'(stall_cyc), 64'(3));

    // Reset mid-operation: third operation presented in the reset cycle
    send(32'h3F800000, 32'h3F800000, 5'd20, 32'h3F800000, 0);
    send(32'h40000000, 32'h40000000, 5'd21, 32'h40800000, 0);
    bus.x1       = 32'h40400000;
    bus.x2       = 32'h40400000;
    bus.in_tag   = 5'd22;
    bus.in_valid = 1'b1;
    rstn         = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rstn         = 1'b1;
    repeat (ST + 2) begin
      @(negedge clk);
      check("post_rst_quiet", 64'(bus.out_valid), 64'(0));
      @(posedge clk);
      #1;
    end
    send(32'h3FC00000, 32'h40000000, 5'd3, 32'h40400000, 1);
    drain();

    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
